// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the register slave's FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam int unsigned REG_COUNT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

endpackage

// File: rtl/ahb_slave_regs.sv
// AHB slave with a 16-word register file (word 0 is a read-only ID),
// configurable wait states and a two-cycle ERROR response.
module ahb_slave_regs
    import ahb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hready_out,
    output logic [1:0]  hresp
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 3;

    // Byte lanes touched by a transfer of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            HSIZE_BYTE: m[off] = 1'b1;
            HSIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic xfer_error(input logic [27:0] addr, input logic [2:0] size,
                                        input logic write);
        logic bad;
        bad = (addr[27:6] != '0);
        bad = bad | (size > HSIZE_WORD);
        bad = bad | ((size == HSIZE_HALF) && addr[0]);
        bad = bad | ((size == HSIZE_WORD) && (addr[1:0] != 2'b00));
        bad = bad | (write && (addr[5:2] == '0));
        return bad;
    endfunction

    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_v,
                                                      input logic [DATA_W-1:0] new_v,
                                                      input logic [3:0]        mask);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    slv_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic               dp_valid;
    logic               dp_write;
    logic [IDX_W-1:0]   dp_idx;
    logic [3:0]         dp_mask;
    logic [DATA_W-1:0]  regs [REG_COUNT];

    logic               accept;
    logic               a_err;
    logic [IDX_W-1:0]   a_idx;
    logic [3:0]         a_mask;
    logic               commit;
    logic [DATA_W-1:0]  wr_value;
    logic [DATA_W-1:0]  dp_rd;
    logic [DATA_W-1:0]  a_rd;
    logic               unused_inputs;

    assign unused_inputs = ^{haddr[31:28], htrans[0]};

    // Address phase is only looked at while this slave is itself ready.
    assign accept   = hready_out & hsel & hready & htrans[1];
    assign a_idx    = haddr[5:2];
    assign a_err    = xfer_error(haddr[27:0], hsize, hwrite);
    assign a_mask   = lane_mask(hsize, haddr[1:0]);
    assign commit   = dp_valid & hready_out & dp_write;
    assign wr_value = merge_lanes(regs[dp_idx], hwdata, dp_mask);
    assign dp_rd    = (dp_idx == '0) ? ID_VALUE : regs[dp_idx];

    // Zero-wait reads launched on a write's completing edge see that write.
    assign a_rd = (a_idx == '0)                ? ID_VALUE :
                  (commit && (dp_idx == a_idx)) ? wr_value : regs[a_idx];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_idx     <= '0;
            dp_mask    <= '0;
            hready_out <= 1'b1;
            hresp      <= HRESP_OKAY;
            hrdata     <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            hrdata <= '0;
            if (commit) regs[dp_idx] <= wr_value;

            case (state)
                ST_IDLE, ST_ERR2: begin
                    state      <= ST_IDLE;
                    dp_valid   <= 1'b0;
                    hready_out <= 1'b1;
                    hresp      <= HRESP_OKAY;
                    if (accept) begin
                        dp_write <= hwrite;
                        dp_idx   <= a_idx;
                        dp_mask  <= a_mask;
                        if (a_err) begin
                            state      <= ST_ERR1;
                            hready_out <= 1'b0;
                            hresp      <= HRESP_ERROR;
                        end else begin
                            dp_valid <= 1'b1;
                            if (WAIT_STATES == 0) begin
                                if (!hwrite) hrdata <= a_rd;
                            end else begin
                                state      <= ST_WAIT;
                                cnt        <= CNT_W'(WAIT_STATES - 1);
                                hready_out <= 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state      <= ST_IDLE;
                        hready_out <= 1'b1;
                        if (!dp_write) hrdata <= dp_rd;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    hready_out <= 1'b1;
                    hresp      <= HRESP_ERROR;
                end
                default: begin
                    state      <= ST_IDLE;
                    hready_out <= 1'b1;
                    hresp      <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_regs.sv
// Bench for ahb_slave_regs: directed tables plus random traffic on a zero-wait
// and a three-wait instance, checked cycle by cycle against a register model.
module tb_ahb_slave_regs;

    localparam logic [31:0] ID  = 32'hA5B0_0001;
    localparam int          WS1 = 3;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel_v     [2];
    logic [31:0] haddr_v    [2];
    logic [1:0]  htrans_v   [2];
    logic        hwrite_v   [2];
    logic [2:0]  hsize_v    [2];
    logic [31:0] hwdata_v   [2];
    logic [31:0] hrdata_v   [2];
    logic        hready_out_v [2];
    logic [1:0]  hresp_v    [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mem [2][16];

    always #5 hclk = ~hclk;

    ahb_slave_regs #(.WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[0]), .haddr(haddr_v[0]),
        .htrans(htrans_v[0]), .hwrite(hwrite_v[0]), .hsize(hsize_v[0]),
        .hwdata(hwdata_v[0]), .hready(hready_out_v[0]), .hrdata(hrdata_v[0]),
        .hready_out(hready_out_v[0]), .hresp(hresp_v[0])
    );

    ahb_slave_regs #(.WAIT_STATES(WS1)) u_ws3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[1]), .haddr(haddr_v[1]),
        .htrans(htrans_v[1]), .hwrite(hwrite_v[1]), .hsize(hsize_v[1]),
        .hwdata(hwdata_v[1]), .hready(hready_out_v[1]), .hrdata(hrdata_v[1]),
        .hready_out(hready_out_v[1]), .hresp(hresp_v[1])
    );

    function automatic vec_t mk(logic [1:0] trans, logic write, logic [31:0] addr,
                                logic [2:0] size, logic [31:0] wdata,
                                logic err, logic [31:0] rdata);
        vec_t v;
        v.trans = trans; v.write = write; v.addr = addr; v.size = size;
        v.wdata = wdata; v.exp_err = err; v.exp_rdata = rdata;
        return v;
    endfunction

    // Reference model: legality and lane rules with plain arithmetic.
    function automatic bit m_err(vec_t v);
        int unsigned a   = v.addr & 32'h0FFF_FFFF;
        int unsigned sz  = v.size;
        return (a >= 64) || (sz > 2) || (sz == 1 && a % 2 != 0) ||
               (sz == 2 && a % 4 != 0) || (v.write && (a / 4) % 16 == 0);
    endfunction

    function automatic void m_apply(int d, vec_t v);
        int idx = int'(v.addr[5:2]);
        int off = int'(v.addr[1:0]);
        if (!v.trans[1] || !v.write || m_err(v)) return;
        for (int b = 0; b < 4; b++) begin
            if (v.size == 2 || (v.size == 1 && b / 2 == off / 2) || (v.size == 0 && b == off))
                mem[d][idx][8*b +: 8] = v.wdata[8*b +: 8];
        end
    endfunction

    function automatic void m_fill(int d, inout vec_t v);
        int idx = int'(v.addr[5:2]);
        v.exp_err   = m_err(v);
        v.exp_rdata = (v.exp_err || v.write) ? 32'h0 : (idx == 0 ? ID : mem[d][idx]);
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
    endfunction

    task automatic chk(string what, logic [34:0] act, logic [34:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy=%0b resp=%0b rdata=%08h, want rdy=%0b resp=%0b rdata=%08h",
                     what, act[34], act[33:32], act[31:0], exp[34], exp[33:32], exp[31:0]);
        end
    endtask

    function automatic logic [34:0] obs(int d);
        return {hready_out_v[d], hresp_v[d], hrdata_v[d]};
    endfunction

    task automatic drive_idle(int d);
        hsel_v[d] = 1'b0; htrans_v[d] = 2'b00; haddr_v[d] = 32'h0;
        hwrite_v[d] = 1'b0; hsize_v[d] = 3'd2;
    endtask

    task automatic drive_addr(int d, vec_t v);
        hsel_v[d] = 1'b1; htrans_v[d] = v.trans; haddr_v[d] = v.addr;
        hwrite_v[d] = v.write; hsize_v[d] = v.size;
    endtask

    // Noise on the address bus while the slave is stalled; it must be ignored.
    task automatic drive_garbage(int d);
        hsel_v[d] = 1'b1; htrans_v[d] = 2'b10; haddr_v[d] = $urandom();
        hwrite_v[d] = 1'($urandom_range(0, 1)); hsize_v[d] = 3'($urandom_range(0, 7));
    endtask

    // Pipelined master: issue each vector, check every data-phase cycle of the previous one.
    task automatic run_seq(int d, input vec_t q[$], input bit use_model, input string tag);
        vec_t prev, cur;
        bit   have_prev = 0;
        int   k, ws;
        logic [34:0] exp;
        ws = (d == 0) ? 0 : WS1;
        for (int i = 0; i <= q.size(); i++) begin
            if (have_prev) m_apply(d, prev);
            if (i < q.size()) begin
                cur = q[i];
                if (use_model) m_fill(d, cur);
            end
            k = (!have_prev || !prev.trans[1]) ? 1 : (prev.exp_err ? 2 : ws + 1);
            for (int c = 1; c <= k; c++) begin
                @(negedge hclk);
                if (c < k) drive_garbage(d);
                else if (i < q.size()) drive_addr(d, cur);
                else drive_idle(d);
                hwdata_v[d] = (c == k && have_prev) ? prev.wdata : $urandom();
                if (!have_prev || !prev.trans[1])
                    exp = {1'b1, 2'b00, 32'h0};
                else if (prev.exp_err)
                    exp = {(c == k), 2'b01, 32'h0};
                else
                    exp = {(c == k), 2'b00, (c == k && !prev.write) ? prev.exp_rdata : 32'h0};
                chk($sformatf("%s[%0d].c%0d", tag, i - 1, c), obs(d), exp);
            end
            have_prev = (i < q.size());
            prev = cur;
        end
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        int   r = $urandom_range(0, 9);
        v.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        v.write = 1'($urandom_range(0, 1));
        v.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        v.addr  = {4'($urandom()), 22'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 15) == 0) v.addr[$urandom_range(6, 27)] = 1'b1;
        if ($urandom_range(0, 3) != 0) begin
            if (v.size == 1) v.addr[0] = 1'b0;
            if (v.size == 2) v.addr[1:0] = 2'b00;
        end
        v.wdata = $urandom();
        v.exp_err = 1'b0;
        v.exp_rdata = 32'h0;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t dir0 [$];
        vec_t dir1 [$];
        vec_t post [$];
        vec_t rnd  [$];

        // {trans, write, addr, size, wdata, expect_error, expect_rdata}
        dir0.push_back(mk(2'b10, 1, 32'h08, 3'd2, 32'hDEAD_BEEF, 0, 32'h0));
        dir0.push_back(mk(2'b10, 0, 32'h08, 3'd2, 32'h0,         0, 32'hDEAD_BEEF));
        dir0.push_back(mk(2'b10, 0, 32'h04, 3'd2, 32'h0,         0, 32'h0));
        dir0.push_back(mk(2'b10, 1, 32'h0D, 3'd0, 32'h1122_7F33, 0, 32'h0));
        dir0.push_back(mk(2'b11, 0, 32'h0C, 3'd2, 32'h0,         0, 32'h0000_7F00));
        dir0.push_back(mk(2'b10, 1, 32'h0F, 3'd1, 32'hFFFF_FFFF, 1, 32'h0));
        dir0.push_back(mk(2'b10, 0, 32'h0C, 3'd2, 32'h0,         0, 32'h0000_7F00));
        dir0.push_back(mk(2'b10, 1, 32'h00, 3'd2, 32'h1234_5678, 1, 32'h0));
        dir0.push_back(mk(2'b10, 1, 32'h40, 3'd2, 32'h1234_5678, 1, 32'h0));
        dir0.push_back(mk(2'b10, 0, 32'h10, 3'd3, 32'h0,         1, 32'h0));
        dir0.push_back(mk(2'b10, 0, 32'h00, 3'd2, 32'h0,         0, ID));
        dir0.push_back(mk(2'b10, 1, 32'h12, 3'd1, 32'hBEEF_0000, 0, 32'h0));
        dir0.push_back(mk(2'b10, 0, 32'h10, 3'd2, 32'h0,         0, 32'hBEEF_0000));
        dir0.push_back(mk(2'b01, 1, 32'h10, 3'd2, 32'h5555_5555, 0, 32'h0));
        dir0.push_back(mk(2'b10, 1, 32'h11, 3'd0, 32'h0000_AB00, 0, 32'h0));
        dir0.push_back(mk(2'b10, 0, 32'h10, 3'd2, 32'h0,         0, 32'hBEEF_AB00));
        dir0.push_back(mk(2'b10, 0, 32'h0E, 3'd1, 32'h0,         0, 32'h0000_7F00));
        dir0.push_back(mk(2'b10, 0, 32'h3C, 3'd2, 32'h0,         0, 32'h0));
        dir0.push_back(mk(2'b10, 0, 32'h09, 3'd2, 32'h0,         1, 32'h0));
        dir0.push_back(mk(2'b00, 0, 32'h08, 3'd2, 32'h0,         0, 32'h0));
        dir0.push_back(mk(2'b10, 0, 32'hF000_0008, 3'd2, 32'h0,  0, 32'hDEAD_BEEF));

        dir1.push_back(mk(2'b10, 0, 32'h00, 3'd2, 32'h0,         0, ID));
        dir1.push_back(mk(2'b10, 1, 32'h08, 3'd2, 32'hDEAD_BEEF, 0, 32'h0));
        dir1.push_back(mk(2'b10, 0, 32'h08, 3'd2, 32'h0,         0, 32'hDEAD_BEEF));
        dir1.push_back(mk(2'b10, 1, 32'h0D, 3'd0, 32'h1122_7F33, 0, 32'h0));
        dir1.push_back(mk(2'b10, 0, 32'h0C, 3'd2, 32'h0,         0, 32'h0000_7F00));
        dir1.push_back(mk(2'b10, 1, 32'h0F, 3'd1, 32'hFFFF_FFFF, 1, 32'h0));
        dir1.push_back(mk(2'b10, 0, 32'h0C, 3'd2, 32'h0,         0, 32'h0000_7F00));
        dir1.push_back(mk(2'b10, 1, 32'h00, 3'd0, 32'h0000_00FF, 1, 32'h0));
        dir1.push_back(mk(2'b11, 0, 32'h08, 3'd2, 32'h0,         0, 32'hDEAD_BEEF));
        dir1.push_back(mk(2'b10, 0, 32'h04, 3'd7, 32'h0,         1, 32'h0));
        dir1.push_back(mk(2'b00, 1, 32'h04, 3'd2, 32'h0,         0, 32'h0));

        post.push_back(mk(2'b10, 0, 32'h10, 3'd2, 32'h0,         0, 32'h0));
        post.push_back(mk(2'b10, 0, 32'h08, 3'd2, 32'h0,         0, 32'h0));
        post.push_back(mk(2'b10, 0, 32'h00, 3'd2, 32'h0,         0, ID));

        m_reset();
        hresetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive_idle(d);
            hwdata_v[d] = 32'h0;
        end
        #12;
        for (int d = 0; d < 2; d++) chk($sformatf("reset_hold%0d", d), obs(d), {1'b1, 2'b00, 32'h0});
        @(negedge hclk);
        hresetn = 1'b1;

        run_seq(0, dir0, 1'b0, "dir_ws0");
        run_seq(1, dir1, 1'b0, "dir_ws3");

        for (int d = 0; d < 2; d++) begin
            rnd.delete();
            for (int i = 0; i < 150; i++) rnd.push_back(rnd_vec());
            run_seq(d, rnd, 1'b1, $sformatf("rnd_ws%0d", d));
        end

        // Reset in the middle of a wait-stated write must abort it asynchronously.
        @(negedge hclk);
        drive_addr(1, mk(2'b10, 1, 32'h10, 3'd2, 32'h0, 0, 32'h0));
        @(negedge hclk);
        drive_garbage(1);
        hwdata_v[1] = 32'h1234_5678;
        chk("rst_wait_stall", obs(1), {1'b0, 2'b00, 32'h0});
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        chk("rst_async_ws3", obs(1), {1'b1, 2'b00, 32'h0});
        chk("rst_async_ws0", obs(0), {1'b1, 2'b00, 32'h0});
        drive_idle(1);
        m_reset();
        @(negedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;

        run_seq(1, post, 1'b0, "post_rst_ws3");
        run_seq(0, post, 1'b0, "post_rst_ws0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
